// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy counter: FSM encoding, default sizing
// and the signed step values applied to the occupancy count.
package parking_pkg;

  localparam int unsigned CAPACITY_DEFAULT = 12;
  localparam int unsigned CNT_W_DEFAULT    = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StUpdate = 2'd1,
    StHold   = 2'd2
  } state_e;

  // Cast to the counter width to obtain the two's-complement step.
  localparam int DELTA_INC  = 1;
  localparam int DELTA_DEC  = -1;
  localparam int DELTA_ZERO = 0;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the building block of the ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder_n.sv
// N-bit ripple-carry adder built from chained full_adder cells.
module ripple_adder_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] carry;

  assign carry[0] = Cin;
  assign Cout     = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (S[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Occupancy counter for a parking lot: arbitrates entry/exit gate requests, grants or
// denies each one exactly once, and keeps registered full/empty/underflow flags.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             entry_deny,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CapVal = CNT_W'(CAPACITY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] delta_q, delta_d;
  logic             entry_grant_q, entry_grant_d;
  logic             exit_grant_q, exit_grant_d;
  logic             entry_deny_q, entry_deny_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] sum;
  logic             adder_cout_unused;

  ripple_adder_n #(
    .N (CNT_W)
  ) u_adder (
    .A    (count_q),
    .B    (delta_q),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (adder_cout_unused)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    delta_d       = delta_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    entry_deny_d  = 1'b0;
    full_d        = full_q;
    empty_d       = empty_q;
    err_d         = err_q;

    unique case (state_q)
      StIdle: begin
        if (entry_req && exit_req) begin
          state_d       = StUpdate;
          entry_grant_d = 1'b1;
          // With an empty lot the exit has nothing to leave: count the entry only.
          if (empty_q) begin
            delta_d = CNT_W'(DELTA_INC);
            err_d   = 1'b1;
          end else begin
            exit_grant_d = 1'b1;
            delta_d      = CNT_W'(DELTA_ZERO);
          end
        end else if (entry_req) begin
          if (full_q) begin
            entry_deny_d = 1'b1;
            state_d      = StHold;
          end else begin
            entry_grant_d = 1'b1;
            delta_d       = CNT_W'(DELTA_INC);
            state_d       = StUpdate;
          end
        end else if (exit_req) begin
          if (empty_q) begin
            err_d   = 1'b1;
            state_d = StHold;
          end else begin
            exit_grant_d = 1'b1;
            delta_d      = CNT_W'(DELTA_DEC);
            state_d      = StUpdate;
          end
        end
      end
      StUpdate: begin
        count_d = sum;
        full_d  = (sum == CapVal);
        empty_d = (sum == '0);
        state_d = StHold;
      end
      StHold: begin
        if (!entry_req && !exit_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      delta_q       <= '0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      entry_deny_q  <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      delta_q       <= delta_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      entry_deny_q  <= entry_deny_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      err_q         <= err_d;
    end
  end

  assign entry_grant   = entry_grant_q;
  assign exit_grant    = exit_grant_q;
  assign entry_deny    = entry_deny_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Randomized and directed bench for parking_occupancy_counter with a lot-level
// occupancy model (integer count plus sticky underflow flag).
module tb_parking_occupancy_counter;

  localparam int unsigned CAPACITY = 12;
  localparam int unsigned CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             entry_req = 1'b0;
  logic             exit_req = 1'b0;
  logic             entry_grant;
  logic             exit_grant;
  logic             entry_deny;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err_underflow;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the lot
  int m_count = 0;
  bit m_err = 1'b0;

  typedef struct {
    int n_eg;
    int n_xg;
    int n_ed;
    logic eg1;
    logic xg1;
    logic ed1;
    logic [CNT_W-1:0] cnt2;
  } obs_t;

  typedef struct {
    int eg;
    int xg;
    int ed;
  } exp_t;

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .entry_grant   (entry_grant),
    .exit_grant    (exit_grant),
    .entry_deny    (entry_deny),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Lot rules: what a request pair should produce and how occupancy changes.
  task automatic model_step(input bit e, input bit x, output exp_t ex);
    ex = '{eg: 0, xg: 0, ed: 0};
    if (e && x) begin
      if (m_count == 0) begin
        ex.eg = 1; m_err = 1'b1; m_count = 1;
      end else begin
        ex.eg = 1; ex.xg = 1;
      end
    end else if (e) begin
      if (m_count == CAPACITY) ex.ed = 1;
      else begin ex.eg = 1; m_count = m_count + 1; end
    end else if (x) begin
      if (m_count == 0) m_err = 1'b1;
      else begin ex.xg = 1; m_count = m_count - 1; end
    end
  endtask

  // Raise the requests for 'high' cycles, then watch the outputs until the FSM settles.
  task automatic drive(input bit e, input bit x, input int high, output obs_t o);
    o.n_eg = 0; o.n_xg = 0; o.n_ed = 0;
    o.eg1 = 1'b0; o.xg1 = 1'b0; o.ed1 = 1'b0; o.cnt2 = '0;
    @(negedge clk);
    entry_req = e;
    exit_req  = x;
    for (int i = 1; i <= high + 4; i++) begin
      @(negedge clk);
      if (entry_grant) o.n_eg++;
      if (exit_grant) o.n_xg++;
      if (entry_deny) o.n_ed++;
      if (i == 1) begin
        o.eg1 = entry_grant; o.xg1 = exit_grant; o.ed1 = entry_deny;
      end
      if (i == 2) o.cnt2 = count;
      if (i == high) begin
        entry_req = 1'b0;
        exit_req  = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_count = 0;
    m_err = 1'b0;
    @(negedge clk);
  endtask

  // Full comparison of one transaction against the model.
  task automatic txn(input string name, input bit e, input bit x, input int high);
    obs_t o;
    exp_t ex;
    model_step(e, x, ex);
    drive(e, x, high, o);
    vectors += 8;
    if (o.n_eg !== ex.eg) begin
      miscompares++; $display("FAIL %s entry_grant pulses: got %0d want %0d", name, o.n_eg, ex.eg);
    end
    if (o.n_xg !== ex.xg) begin
      miscompares++; $display("FAIL %s exit_grant pulses: got %0d want %0d", name, o.n_xg, ex.xg);
    end
    if (o.n_ed !== ex.ed) begin
      miscompares++; $display("FAIL %s entry_deny pulses: got %0d want %0d", name, o.n_ed, ex.ed);
    end
    if ({o.eg1, o.xg1, o.ed1} !== {ex.eg == 1, ex.xg == 1, ex.ed == 1}) begin
      miscompares++;
      $display("FAIL %s pulse timing {eg,xg,ed}: got %b%b%b want %0d%0d%0d", name,
               o.eg1, o.xg1, o.ed1, ex.eg, ex.xg, ex.ed);
    end
    if (o.cnt2 !== CNT_W'(m_count)) begin
      miscompares++; $display("FAIL %s count timing: got %0d want %0d", name, o.cnt2, m_count);
    end
    if (count !== CNT_W'(m_count)) begin
      miscompares++; $display("FAIL %s count: got %0d want %0d", name, count, m_count);
    end
    if ({full, empty} !== {m_count == CAPACITY, m_count == 0}) begin
      miscompares++;
      $display("FAIL %s full/empty: got %b%b want %0d%0d", name, full, empty,
               m_count == CAPACITY, m_count == 0);
    end
    if (err_underflow !== m_err) begin
      miscompares++; $display("FAIL %s err_underflow: got %b want %b", name, err_underflow, m_err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({count, empty, full, entry_grant, exit_grant, entry_deny, err_underflow} !==
        {CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got cnt=%0d e=%b f=%b eg=%b xg=%b ed=%b err=%b want cnt=0 e=1 rest 0",
               count, empty, full, entry_grant, exit_grant, entry_deny, err_underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < int'(CAPACITY); i++) txn("fill", 1'b1, 1'b0, 2);
    txn("fill_deny", 1'b1, 1'b0, 2);
  endtask

  task automatic test_simultaneous_full();
    txn("both_full", 1'b1, 1'b1, 2);
  endtask

  task automatic test_drain_underflow();
    while (m_count > 2) txn("drain", 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) txn("drain_underflow", 1'b0, 1'b1, 2);
  endtask

  task automatic test_simultaneous_empty();
    apply_reset();
    txn("both_empty", 1'b1, 1'b1, 2);
  endtask

  task automatic test_held_request();
    while (m_count < 5) txn("held_setup", 1'b1, 1'b0, 1);
    txn("held_entry", 1'b1, 1'b0, 10);
  endtask

  task automatic test_reset_midop();
    exp_t ex;
    int n_eg;
    while (m_count < 7) txn("midop_setup", 1'b1, 1'b0, 1);
    model_step(1'b1, 1'b0, ex);
    @(negedge clk);
    entry_req = 1'b1;
    @(negedge clk);  // request sampled, FSM now in UPDATE
    rst_n = 1'b0;
    entry_req = 1'b0;
    #1;
    vectors++;
    if ({count, entry_grant} !== {CNT_W'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL reset_midop async: got cnt=%0d eg=%b want cnt=0 eg=0", count, entry_grant);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_count = 0;
    m_err = 1'b0;
    n_eg = 0;
    repeat (4) begin
      @(negedge clk);
      if (entry_grant) n_eg++;
    end
    vectors++;
    if (n_eg !== 0 || count !== CNT_W'(0)) begin
      miscompares++;
      $display("FAIL reset_midop after: got grants=%0d cnt=%0d want grants=0 cnt=0", n_eg, count);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) txn("rand_both", 1'b1, 1'b1, $urandom_range(1, 4));
      else if (r < 6) txn("rand_entry", 1'b1, 1'b0, $urandom_range(1, 4));
      else if (r < 9) txn("rand_exit", 1'b0, 1'b1, $urandom_range(1, 4));
      else txn("rand_idle", 1'b0, 1'b0, $urandom_range(1, 4));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_simultaneous_full();
    test_drain_underflow();
    test_simultaneous_empty();
    test_held_request();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
